// File: rtl/subroutine_return_stack_pkg.sv
// Shared controller definitions for the sequencer and the return-address stack.
package subroutine_return_stack_pkg;

  // Default return-address width; matches the program counter.
  localparam int SRS_ADDR_W = 32;

  // Next-address mux select encodings used by the sequencer.
  typedef enum logic [1:0] {
    NA_SEL_PC         = 2'b00,
    NA_SEL_SUBROUTINE = 2'b01,
    NA_SEL_SECOND     = 2'b10,
    NA_SEL_BRANCH     = 2'b11
  } next_addr_sel_e;

endpackage

// File: rtl/subroutine_return_stack.sv
// Return-address LIFO feeding the microprogrammed controller's next-address mux.
// Outputs are pure decodes of registered state; push/pop take effect at the edge.
module subroutine_return_stack
  import subroutine_return_stack_pkg::*;
#(
  parameter int ADDR_W = SRS_ADDR_W,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              clr_err,
  output logic [ADDR_W-1:0] subroutine_addr,
  output logic [ADDR_W-1:0] second_addr,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] entries_q [DEPTH];
  logic [ADDR_W-1:0] entries_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              is_empty, is_full;
  logic [IDX_W-1:0]  top_idx, second_idx, wr_idx;

  // Status and index decode from the current pointer.
  always_comb begin
    is_empty   = (count_q == '0);
    is_full    = (count_q == CNT_W'(DEPTH));
    top_idx    = IDX_W'(count_q - CNT_W'(1));
    second_idx = IDX_W'(count_q - CNT_W'(2));
    wr_idx     = IDX_W'(count_q);
  end

  // Next-state: push / pop / tail-call replace, with sticky error flags (set beats clear).
  always_comb begin
    entries_d   = entries_q;
    count_d     = count_q;
    overflow_d  = overflow_q & ~clr_err;
    underflow_d = underflow_q & ~clr_err;
    if (push && !pop) begin
      if (is_full) begin
        overflow_d = 1'b1;
      end else begin
        entries_d[wr_idx] = push_addr;
        count_d           = count_q + CNT_W'(1);
      end
    end else if (pop && !push) begin
      if (is_empty) begin
        underflow_d = 1'b1;
      end else begin
        count_d = count_q - CNT_W'(1);
      end
    end else if (push && pop) begin
      if (is_empty) begin
        underflow_d = 1'b1;
      end else begin
        entries_d[top_idx] = push_addr;
      end
    end
  end

  // State registers; reset clears entries, pointer and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      entries_q   <= '{default: '0};
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      entries_q   <= entries_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Output decode: non-valid positions read as zero regardless of stale contents.
  always_comb begin
    subroutine_addr = is_empty ? '0 : entries_q[top_idx];
    second_addr     = (count_q < CNT_W'(2)) ? '0 : entries_q[second_idx];
    count           = count_q;
    empty           = is_empty;
    full            = is_full;
    overflow        = overflow_q;
    underflow       = underflow_q;
  end

endmodule

// File: tb/tb_subroutine_return_stack.sv
// Directed bench for the return-address stack with hand-computed expectations.
module tb_subroutine_return_stack;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic              push, pop, clr_err;
  logic [ADDR_W-1:0] push_addr;
  logic [ADDR_W-1:0] subroutine_addr, second_addr;
  logic [CNT_W-1:0]  count;
  logic              empty, full, overflow, underflow;

  int checks   = 0;
  int failures = 0;

  subroutine_return_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .push            (push),
    .pop             (pop),
    .push_addr       (push_addr),
    .clr_err         (clr_err),
    .subroutine_addr (subroutine_addr),
    .second_addr     (second_addr),
    .count           (count),
    .empty           (empty),
    .full            (full),
    .overflow        (overflow),
    .underflow       (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of controls, then sample 1 time unit after the edge.
  task automatic cyc(input logic rst_i, input logic push_i, input logic pop_i,
                     input logic [ADDR_W-1:0] addr_i, input logic clr_i);
    reset     = rst_i;
    push      = push_i;
    pop       = pop_i;
    push_addr = addr_i;
    clr_err   = clr_i;
    @(posedge clk);
    #1;
    reset = 1'b0; push = 1'b0; pop = 1'b0; push_addr = '0; clr_err = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] e_cnt,
                           input logic [31:0] e_top, input logic [31:0] e_sec,
                           input logic e_ovf, input logic e_unf);
    chk({tag, ".count"}, 32'(count), e_cnt);
    chk({tag, ".top"}, subroutine_addr, e_top);
    chk({tag, ".second"}, second_addr, e_sec);
    chk({tag, ".empty"}, 32'(empty), 32'(e_cnt == 0));
    chk({tag, ".full"}, 32'(full), 32'(e_cnt == DEPTH));
    chk({tag, ".ovf"}, 32'(overflow), 32'(e_ovf));
    chk({tag, ".unf"}, 32'(underflow), 32'(e_unf));
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; push_addr = '0; clr_err = 1'b0;
    @(negedge clk);
    cyc(1, 0, 0, 0, 0);
    chk_state("reset", 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk_state("idle", 0, 0, 0, 0, 0);

    // Two pushes then a pop
    cyc(0, 1, 0, 32'h10, 0);
    chk_state("push10", 1, 32'h10, 0, 0, 0);
    cyc(0, 1, 0, 32'h20, 0);
    chk_state("push20", 2, 32'h20, 32'h10, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk_state("pop1", 1, 32'h10, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk_state("pop2", 0, 0, 0, 0, 0);

    // Fill to DEPTH, overflow, tail-call on full, clear
    for (int i = 1; i <= 4; i++) cyc(0, 1, 0, 32'(i), 0);
    chk_state("fill", 4, 32'h4, 32'h3, 0, 0);
    cyc(0, 1, 0, 32'h5, 0);
    chk_state("ovf", 4, 32'h4, 32'h3, 1, 0);
    cyc(0, 1, 1, 32'h9, 0);
    chk_state("tailfull", 4, 32'h9, 32'h3, 1, 0);
    cyc(0, 0, 0, 0, 1);
    chk_state("clrovf", 4, 32'h9, 32'h3, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk_state("drain3", 3, 32'h3, 32'h2, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk_state("drain1", 1, 32'h1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk_state("drain0", 0, 0, 0, 0, 0);

    // Underflow cases
    cyc(0, 0, 1, 0, 0);
    chk_state("unf", 0, 0, 0, 0, 1);
    cyc(0, 1, 1, 32'h7, 0);
    chk_state("tailempty", 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk_state("clrunf", 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 1);
    chk_state("setwins", 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk_state("clrunf2", 0, 0, 0, 0, 0);

    // Tail-call on a partially filled stack
    cyc(0, 1, 0, 32'hA, 0);
    cyc(0, 1, 1, 32'hB, 0);
    chk_state("tailmid", 1, 32'hB, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);

    // Nested call/return
    cyc(0, 1, 0, 32'h100, 0);
    chk_state("nest1", 1, 32'h100, 0, 0, 0);
    cyc(0, 1, 0, 32'h200, 0);
    cyc(0, 1, 0, 32'h300, 0);
    chk_state("nest3", 3, 32'h300, 32'h200, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk_state("ret1", 2, 32'h200, 32'h100, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk_state("ret2", 1, 32'h100, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk_state("ret3", 0, 0, 0, 0, 0);

    // Reset overrides a same-cycle push mid-nesting
    cyc(0, 1, 0, 32'h30, 0);
    cyc(0, 1, 0, 32'h40, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk_state("preunf", 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 32'h30, 0);
    cyc(0, 1, 0, 32'h40, 0);
    chk_state("prerst", 2, 32'h40, 32'h30, 0, 1);
    cyc(1, 1, 0, 32'h50, 0);
    chk_state("rstpush", 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 32'h60, 0);
    chk_state("postrst", 1, 32'h60, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
